imem_param: RTL and testbench
=============================

IMEM_PARAM -- requirements
Module: imem_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words, a power of 2, at least 2.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000000, word returned on a faulted fetch.
REQ-004 SHALL have port clk, input, 1, the only clock; all state on the rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, fetch request present.
REQ-007 SHALL have port req_ready, output, 1, block accepts a fetch this cycle.
REQ-008 SHALL have port req_addr, input, 32, byte address (PC).
REQ-009 SHALL have port rsp_valid, output, 1, response register holds a result.
REQ-010 SHALL have port rsp_ready, input, 1, consumer takes the response.
REQ-011 SHALL have port rsp_instr, output, DATA_W, fetched instruction.
REQ-012 SHALL have port rsp_fault, output, 1, response is for a misaligned or out-of-range address.
REQ-013 SHALL have port rsp_perr, output, 1, parity error on the response word.
REQ-014 SHALL have port prog_we, input, 1, program-load write strobe.
REQ-015 SHALL have port prog_idx, input, log2(DEPTH), word index to write.
REQ-016 SHALL have port prog_data, input, DATA_W, word to write.
REQ-017 SHALL have port fetch_cnt, output, 32, count of accepted fetches.

Function
REQ-018 SHALL accept a fetch when req_valid && req_ready, with req_ready = !rsp_valid || rsp_ready (combinational).
REQ-019 SHALL present the result of an accepted fetch on rsp_* exactly one cycle later, with rsp_valid set.
REQ-020 SHALL hold rsp_valid, rsp_instr, rsp_fault and rsp_perr stable while rsp_valid && !rsp_ready.
REQ-021 SHALL clear rsp_valid after rsp_valid && rsp_ready when no new fetch is accepted in the same cycle; a same-cycle accept SHALL reload the register (back-to-back, one per cycle).
REQ-022 SHALL form the word index as req_addr[log2(DEPTH)+1:2].
REQ-023 SHALL flag a fault when req_addr[1:0] != 0 or req_addr >= DEPTH*4; a faulted response SHALL carry rsp_instr = NOP_WORD, rsp_fault = 1 and rsp_perr = 0.
REQ-024 SHALL write prog_data to word prog_idx on a clock edge with prog_we = 1, independently of the fetch handshake.
REQ-025 SHALL return the old word (read-first) when a write and an accepted fetch target the same index in the same cycle.
REQ-026 SHALL increment fetch_cnt by 1 per accepted fetch, faulted fetches included, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-027 SHALL NOT reset the memory array; contents persist across rst, and simulation SHALL initialise every word to NOP_WORD.

Reset
REQ-028 SHALL, while rst = 1 at a clock edge, set rsp_valid = 0, rsp_instr = 0, rsp_fault = 0, rsp_perr = 0 and fetch_cnt = 0.
REQ-029 SHALL drive req_ready = 0 while rst = 1 and accept no fetch; a response pending when reset is asserted SHALL be discarded.
REQ-030 SHALL still perform a prog_we write while rst = 1.

Configuration
REQ-031 SHALL, with IMEM_PARITY_EN defined, store one even-parity bit per word on every write (prog_we and simulation init) and set rsp_perr = 1 on a non-faulted response whose stored parity mismatches the stored word.
REQ-032 SHALL, without IMEM_PARITY_EN, store no parity bit and tie rsp_perr to 0.

Verification
REQ-033 SHALL cover: prog writes idx 0 = 32'h00221820, idx 1 = 32'h2109000A; fetch 0x0 then 0x4 with rsp_ready = 1 -> the two words on consecutive cycles, fetch_cnt = 2.
REQ-034 SHALL cover: fetch 0x6 and fetch 0x100 (DEPTH = 64) -> rsp_instr = NOP_WORD, rsp_fault = 1, fetch_cnt increments on each.
REQ-035 SHALL cover: rsp_ready = 0 for 3 cycles with a response pending -> req_ready = 0, rsp_* stable; rsp_ready = 1 -> next fetch accepted in the same cycle.
REQ-036 SHALL cover: same-cycle prog_we to idx 5 (32'hAAAA5555) and fetch 0x14 -> old word returned; refetch 0x14 -> 32'hAAAA5555.
REQ-037 SHALL cover: rst asserted with a response pending -> rsp_valid = 0, fetch_cnt = 0 next cycle; memory contents unchanged after reset.
REQ-038 SHALL cover, with IMEM_PARITY_EN: force-flip a stored data bit at idx 2 and fetch 0x8 -> rsp_perr = 1; without the macro -> rsp_perr = 0.

Source files
------------

// File: rtl/imem_param.sv
// Instruction memory with a single registered fetch response and a program-load
// write port. Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module imem_param #(
   parameter int unsigned          DATA_W   = 32,
   parameter int unsigned          DEPTH    = 64,
   parameter logic [DATA_W-1:0]    NOP_WORD = 32'h00000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [31:0]              req_addr,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_instr,
   output logic                     rsp_fault,
   output logic                     rsp_perr,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_idx,
   input  logic [DATA_W-1:0]        prog_data,
   output logic [31:0]              fetch_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

   // Handshake: a transfer happens on a rising edge where valid && ready are both
   // high; the response register holds its payload until rsp_ready takes it.

   // Array is never reset; contents survive rst and start out as NOP_WORD.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: NOP_WORD};

   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic              rsp_perr_q,  rsp_perr_d;
   logic [31:0]       fetch_cnt_q, fetch_cnt_d;

   logic              accept;
   logic              addr_fault;
   logic [AW-1:0]     rd_idx;
   logic [DATA_W-1:0] rd_word;
   logic              rd_perr;

   assign req_ready  = !rst && (!rsp_valid_q || rsp_ready);
   assign accept     = req_valid && req_ready;
   assign rd_idx     = req_addr[AW+1:2];
   assign addr_fault = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);
   assign rd_word    = mem_q[rd_idx];

`ifdef IMEM_PARITY_EN
   logic par_q [DEPTH] = '{default: ^NOP_WORD};

   always_ff @(posedge clk) begin
      if (prog_we) par_q[prog_idx] <= ^prog_data;
   end

   assign rd_perr = (par_q[rd_idx] != ^rd_word);
`else
   assign rd_perr = 1'b0;
`endif

   // Write uses NBA, so a same-cycle fetch of the same index sees the old word.
   always_ff @(posedge clk) begin
      if (prog_we) mem_q[prog_idx] <= prog_data;
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_instr_d = rsp_instr_q;
      rsp_fault_d = rsp_fault_q;
      rsp_perr_d  = rsp_perr_q;
      fetch_cnt_d = fetch_cnt_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_instr_d = addr_fault ? NOP_WORD : rd_word;
         rsp_fault_d = addr_fault;
         rsp_perr_d  = !addr_fault && rd_perr;
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= '0;
         rsp_fault_q <= 1'b0;
         rsp_perr_q  <= 1'b0;
         fetch_cnt_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_perr_q  <= rsp_perr_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_instr = rsp_instr_q;
   assign rsp_fault = rsp_fault_q;
   assign rsp_perr  = rsp_perr_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_param.sv
// Bench for imem_param: directed scenarios followed by random traffic, all checked
// against an array-based reference model of the fetch/response behaviour.
module tb_imem_param;

   localparam int          DEPTH = 64;
   localparam int          AW    = 6;
   localparam logic [31:0] NOP   = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_instr;
   logic        rsp_fault;
   logic        rsp_perr;
   logic        prog_we;
   logic [AW-1:0] prog_idx;
   logic [31:0] prog_data;
   logic [31:0] fetch_cnt;

   imem_param #(.DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
      .rsp_fault(rsp_fault), .rsp_perr(rsp_perr),
      .prog_we(prog_we), .prog_idx(prog_idx), .prog_data(prog_data),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_mem [DEPTH];
   bit          m_corrupt [DEPTH];
   bit          m_valid;
   bit          m_known;
   logic [31:0] m_instr;
   bit          m_fault;
   bit          m_perr;
   logic [31:0] m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check ready, advance model, check outputs at next negedge.
   task automatic step(input bit rv, input logic [31:0] addr, input bit rr,
                       input bit we, input logic [AW-1:0] idx, input logic [31:0] data,
                       input bit r);
      bit exp_ready, acc, flt;
      req_valid = rv; req_addr = addr; rsp_ready = rr;
      prog_we = we; prog_idx = idx; prog_data = data; rst = r;
      #1;
      exp_ready = !r && (!m_valid || rr);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      acc = rv && exp_ready;
      @(posedge clk);
      if (r) begin
         m_valid = 0; m_instr = 0; m_fault = 0; m_perr = 0; m_cnt = 0; m_known = 1;
      end else if (acc) begin
         flt = (addr % 4 != 0) || (addr >= DEPTH * 4);
         m_valid = 1; m_known = 1; m_fault = flt;
         m_instr = flt ? NOP : m_mem[addr / 4];
`ifdef IMEM_PARITY_EN
         m_perr = !flt && m_corrupt[addr / 4];
`else
         m_perr = 0;
`endif
         m_cnt = m_cnt + 1;
      end else if (rr) begin
         m_valid = 0; m_known = 0;
      end
      if (we) begin
         m_mem[idx] = data;
         m_corrupt[idx] = 0;
      end
      @(negedge clk);
      chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
      if (m_known) begin
         chk("rsp_instr", 64'(rsp_instr), 64'(m_instr));
         chk("rsp_fault", 64'(rsp_fault), 64'(m_fault));
         chk("rsp_perr",  64'(rsp_perr),  64'(m_perr));
      end
      chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
   endtask

   task automatic fetch(input logic [31:0] addr, input bit rr);
      step(1, addr, rr, 0, '0, '0, 0);
   endtask

   task automatic idle(input bit rr);
      step(0, '0, rr, 0, '0, '0, 0);
   endtask

   task automatic prog(input logic [AW-1:0] idx, input logic [31:0] data);
      step(0, '0, 1, 1, idx, data, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = NOP;
         m_corrupt[i] = 0;
      end
      m_valid = 0; m_known = 0; m_instr = 0; m_fault = 0; m_perr = 0; m_cnt = 0;
      rst = 1; req_valid = 0; req_addr = 0; rsp_ready = 0;
      prog_we = 0; prog_idx = 0; prog_data = 0;
      @(negedge clk);

      // Reset state
      step(0, '0, 0, 0, '0, '0, 1);
      step(0, '0, 0, 0, '0, '0, 1);

      // Program two words and fetch them back to back
      prog(6'd0, 32'h00221820);
      prog(6'd1, 32'h2109000A);
      fetch(32'h0, 1);
      fetch(32'h4, 1);
      idle(1);

      // Misaligned and out-of-range fetches
      fetch(32'h6, 1);
      fetch(32'h100, 1);
      fetch(32'hFFFF_FFFC, 1);
      fetch(32'h0000_00FC, 1);
      idle(1);

      // Backpressure: response held for 3 cycles, then same-cycle take and accept
      fetch(32'h0, 0);
      for (int i = 0; i < 3; i++) step(1, 32'h4, 0, 0, '0, '0, 0);
      step(1, 32'h4, 1, 0, '0, '0, 0);
      idle(1);

      // Read-first on same-cycle write and fetch
      step(1, 32'h14, 1, 1, 6'd5, 32'hAAAA5555, 0);
      fetch(32'h14, 1);
      idle(1);

      // Reset with a response pending, contents survive, write during reset lands
      fetch(32'h4, 0);
      step(0, '0, 0, 1, 6'd7, 32'h1234_5678, 1);
      fetch(32'h0, 1);
      fetch(32'h4, 1);
      fetch(32'h1C, 1);
      idle(1);

      // Corrupt a stored bit of idx 2 behind the write port
      prog(6'd2, 32'h0F0F_0F0F);
      dut.mem_q[2] = dut.mem_q[2] ^ 32'h0000_0010;
      m_mem[2] = m_mem[2] ^ 32'h0000_0010;
      m_corrupt[2] = 1;
      fetch(32'h8, 1);
      idle(1);
      prog(6'd2, 32'h0F0F_0F0F);
      fetch(32'h8, 1);
      idle(1);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         endcase
         step(bit'($urandom_range(0, 3) != 0), a, bit'($urandom_range(0, 2) != 0),
              bit'($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH - 1)), $urandom,
              bit'($urandom_range(0, 59) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
